seq_mult_64: RTL and testbench
==============================

# seq_mult_64

Multi-cycle 64×64 shift-and-add multiplier for the CPU's MUL, SMULH and UMULH instructions. It is the sequential counterpart to the single-cycle bitwise and arithmetic units in the ALU. The EX stage hands it two operands with a one-cycle `start` pulse and stalls until `done` pulses. It then receives the full 128-bit product as `prod_lo` (MUL) and `prod_hi` (SMULH/UMULH).

## Interface
- `WIDTH`, 64: operand width; the product is 2×WIDTH.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: request; sampled only when `busy` is 0.
- `is_signed` in 1: 1 for two's-complement operands, 0 for unsigned; captured with `start`.
- `a` in WIDTH: multiplicand; captured with `start`.
- `b` in WIDTH: multiplier; captured with `start`.
- `busy` out 1: high while an operation is in progress (RUN or FIX).
- `done` out 1: single-cycle pulse; the result is valid.
- `prod_lo` out WIDTH: low half of the product.
- `prod_hi` out WIDTH: high half of the product.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: 64 iterations.
  - FIX: sign correction.
  - DONE: pulse `done`.
- IDLE: if `start` is high, go to RUN.
  - Latch `|a|` into the multiplicand register (`a` if unsigned).
  - Initialise the accumulator {hi, lo} = {0, `|b|`} (`b` if unsigned).
  - Record the result sign: `a[63]` ^ `b[63]` when signed, else 0.
  - Clear the 7-bit iteration counter.
- RUN, each cycle:
  - If `lo[0]` = 1, add the multiplicand to `hi` as a 65-bit sum that keeps the carry.
  - Shift {carry, hi, lo} right by 1.
  - Increment the counter. After iteration 64 (counter = 63 on entry), go to FIX.
- Magnitude of -2^63 is 2^63. It fits as unsigned 64-bit, so there is no overflow special case.
- FIX: if the sign bit is set, replace {hi, lo} with its 128-bit two's complement. Go to DONE.
- DONE:
  - Assert `done`.
  - `prod_hi`/`prod_lo` present the accumulator.
  - Go to IDLE unconditionally.
- Outputs hold the last product until the next accepted `start`. They are not cleared on entry to IDLE.
- `start` while `busy` = 1 is ignored. It is not queued.
- `start` in the DONE cycle is ignored. The requester must wait for IDLE.

## Timing
- Reset values:
  - state = IDLE
  - `busy` = 0
  - `done` = 0
  - `prod_lo` = 0
  - `prod_hi` = 0
  - counter = 0
- Accept edge E0: `start` is sampled high in IDLE.
  - `busy` rises after E0.
  - RUN occupies cycles 1–64.
  - FIX is cycle 65.
  - `done` is high during cycle 66 only.
  - `busy` is 0 in cycle 66.
- Fixed latency: 66 cycles from the accept edge to the `done` cycle, independent of operand values and sign.
- Next `start` can be accepted at the edge ending cycle 67 (back in IDLE). Back-to-back throughput is one result per 67 cycles.
- `reset` asserted mid-RUN/FIX: immediate return to IDLE, with all outputs at their reset values and no `done` pulse.
- Operand inputs may change freely after the accept edge.

## Structure
- Shared package `mult_pkg`:
  - `mult_state_t` enum {IDLE, RUN, FIX, DONE}.
  - `MULT_ITERS` = 64.
  - `MULT_CNT_W` = 7.
- One natural sub-module, `mult_datapath`:
  - accumulator register, 65-bit adder and shift.
  - 128-bit negate.
  - magnitude conversion.
- The top level holds the FSM, the counter and the handshake.

## Test plan
- Unsigned `a`=3, `b`=5, `start` pulsed at E0 → `busy` for cycles 1–65; `done` only in cycle 66; `prod_lo`=15, `prod_hi`=0.
- Unsigned `a`=`b`=0xFFFF_FFFF_FFFF_FFFF → `prod_hi`=0xFFFF_FFFF_FFFF_FFFE, `prod_lo`=1.
- Signed `a`=-2, `b`=3 → `prod_lo`=0xFFFF_FFFF_FFFF_FFFA, `prod_hi`=0xFFFF_FFFF_FFFF_FFFF.
- Signed `a`=`b`=0x8000_0000_0000_0000 → `prod_hi`=0x4000_0000_0000_0000, `prod_lo`=0.
- Second `start` (`a`=7, `b`=7) at cycle 10 of a running 3×5 → ignored; `done` at cycle 66 with 15. A fresh `start` at cycle 67 then yields 49 at cycle 133.
- `reset` low at cycle 30 of an operation → `busy`, `done` and the products are 0 immediately. There is no `done` pulse afterwards. A new operation after release completes normally.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 64x64 multiplier.
package mult_pkg;
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t;
   localparam int unsigned MULT_ITERS = 64;
   localparam int unsigned MULT_CNT_W = 7;
endpackage

// File: rtl/mult_datapath.sv
// Shift-and-add datapath: operand magnitude conversion, {hi, lo} accumulator,
// 65-bit add-with-carry step and final 128-bit negate.
module mult_datapath #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             fix,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   logic [WIDTH-1:0]   mcand;
   logic               neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_neg;

   always_comb begin
      // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude
      a_mag   = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag   = (is_signed && b[WIDTH-1]) ? -b : b;
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      acc_neg = -{hi, lo};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand <= '0;
         neg   <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else if (load) begin
         mcand <= a_mag;
         neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         hi    <= '0;
         lo    <= b_mag;
      end else if (step) begin
         hi <= sum[WIDTH:1];
         lo <= {sum[0], lo[WIDTH-1:1]};
      end else if (fix && neg) begin
         {hi, lo} <= acc_neg;
      end
   end
endmodule

// File: rtl/seq_mult_64.sv
// Multi-cycle 64x64 signed/unsigned multiplier: FSM, iteration counter and
// start/busy/done handshake around mult_datapath.
module seq_mult_64
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi
);
   mult_state_t           state;
   mult_state_t           next_state;
   logic [MULT_CNT_W-1:0] cnt;
   logic                  load;
   logic                  step;
   logic                  fix;
   logic                  last_iter;

   assign last_iter = (cnt == MULT_CNT_W'(MULT_ITERS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (load)
            cnt <= '0;
         else if (step)
            cnt <= cnt + MULT_CNT_W'(1);
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      fix        = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last_iter)
               next_state = FIX;
         end
         FIX: begin
            busy       = 1'b1;
            fix        = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   mult_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .fix       (fix),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .hi        (prod_hi),
      .lo        (prod_lo)
   );
endmodule

// File: tb/tb_seq_mult_64.sv
// Directed self-checking bench for seq_mult_64: timing, products, ignored starts and mid-run reset.
module tb_seq_mult_64;
   logic        clk;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [63:0] a;
   logic [63:0] b;
   logic        busy;
   logic        done;
   logic [63:0] prod_lo;
   logic [63:0] prod_hi;

   int checks   = 0;
   int failures = 0;

   seq_mult_64 #(.WIDTH(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .prod_lo   (prod_lo),
      .prod_hi   (prod_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Pulse start for exactly one rising edge, then scramble the operands.
   task automatic do_start(input logic [63:0] av, input logic [63:0] bv, input logic sgn);
      @(negedge clk);
      start     = 1'b1;
      a         = av;
      b         = bv;
      is_signed = sgn;
      @(posedge clk);
      #1;
      start     = 1'b0;
      a         = {$urandom, $urandom};
      b         = {$urandom, $urandom};
      is_signed = ~sgn;
   endtask

   // Cycles from the accept edge to the done cycle, or -1 if done never arrives.
   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cyc++;
         if (done) return;
      end
      cyc = -1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (prod_lo !== 64'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", prod_lo); end
      checks++; if (prod_hi !== 64'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", prod_hi); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_basic_timing;
      do_start(64'd3, 64'd5, 1'b0);
      for (int k = 1; k <= 67; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== (k <= 65)) begin
            failures++; $display("FAIL busy_cycle%0d got=%b exp=%b", k, busy, (k <= 65));
         end
         checks++;
         if (done !== (k == 66)) begin
            failures++; $display("FAIL done_cycle%0d got=%b exp=%b", k, done, (k == 66));
         end
         if (k >= 66) begin
            checks++; if (prod_lo !== 64'd15) begin failures++; $display("FAIL basic_lo_c%0d got=%h exp=%h", k, prod_lo, 64'd15); end
            checks++; if (prod_hi !== 64'd0) begin failures++; $display("FAIL basic_hi_c%0d got=%h exp=0", k, prod_hi); end
         end
      end
   endtask

   task automatic test_products;
      logic [63:0] va [6];
      logic [63:0] vb [6];
      logic        vs [6];
      logic [63:0] eh [6];
      logic [63:0] el [6];
      int          cyc;
      va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'hFFFF_FFFF_FFFF_FFFF; vs[0] = 1'b0;
      eh[0] = 64'hFFFF_FFFF_FFFF_FFFE; el[0] = 64'd1;
      va[1] = 64'hFFFF_FFFF_FFFF_FFFE; vb[1] = 64'd3; vs[1] = 1'b1;
      eh[1] = 64'hFFFF_FFFF_FFFF_FFFF; el[1] = 64'hFFFF_FFFF_FFFF_FFFA;
      va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000; vs[2] = 1'b1;
      eh[2] = 64'h4000_0000_0000_0000; el[2] = 64'd0;
      va[3] = 64'hFFFF_FFFF_FFFF_FFFE; vb[3] = 64'd3; vs[3] = 1'b0;
      eh[3] = 64'd2;                   el[3] = 64'hFFFF_FFFF_FFFF_FFFA;
      va[4] = 64'hFFFF_FFFF_FFFF_FFFF; vb[4] = 64'hFFFF_FFFF_FFFF_FFFF; vs[4] = 1'b1;
      eh[4] = 64'd0;                   el[4] = 64'd1;
      va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'd1; vs[5] = 1'b1;
      eh[5] = 64'hFFFF_FFFF_FFFF_FFFF; el[5] = 64'h8000_0000_0000_0000;
      for (int i = 0; i < 6; i++) begin
         do_start(va[i], vb[i], vs[i]);
         wait_done(cyc);
         checks++; if (cyc !== 66) begin failures++; $display("FAIL latency_v%0d got=%0d exp=66", i, cyc); end
         checks++; if (prod_hi !== eh[i]) begin failures++; $display("FAIL prod_hi_v%0d got=%h exp=%h", i, prod_hi, eh[i]); end
         checks++; if (prod_lo !== el[i]) begin failures++; $display("FAIL prod_lo_v%0d got=%h exp=%h", i, prod_lo, el[i]); end
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      cyc = -1;
      do_start(64'd3, 64'd5, 1'b0);
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 10) begin
            start = 1'b1; a = 64'd7; b = 64'd7; is_signed = 1'b0;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            cyc = c;
            break;
         end
      end
      checks++; if (cyc !== 66) begin failures++; $display("FAIL ignored_start_latency got=%0d exp=66", cyc); end
      checks++; if (prod_lo !== 64'd15) begin failures++; $display("FAIL ignored_start_lo got=%h exp=%h", prod_lo, 64'd15); end
      checks++; if (prod_hi !== 64'd0) begin failures++; $display("FAIL ignored_start_hi got=%h exp=0", prod_hi); end
      do_start(64'd7, 64'd7, 1'b0);
      wait_done(cyc);
      checks++; if (67 + cyc !== 133) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=133", 67 + cyc); end
      checks++; if (prod_lo !== 64'd49) begin failures++; $display("FAIL b2b_lo got=%h exp=%h", prod_lo, 64'd49); end
      checks++; if (prod_hi !== 64'd0) begin failures++; $display("FAIL b2b_hi got=%h exp=0", prod_hi); end
   endtask

   task automatic test_reset_mid_run;
      int cyc;
      int pulses;
      do_start(64'd3, 64'd5, 1'b0);
      repeat (30) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
      checks++; if (prod_lo !== 64'd0) begin failures++; $display("FAIL midreset_lo got=%h exp=0", prod_lo); end
      checks++; if (prod_hi !== 64'd0) begin failures++; $display("FAIL midreset_hi got=%h exp=0", prod_hi); end
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL post_reset_activity got=%0d exp=0", pulses); end
      do_start(64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 1'b1);
      wait_done(cyc);
      checks++; if (cyc !== 66) begin failures++; $display("FAIL post_reset_latency got=%0d exp=66", cyc); end
      checks++; if (prod_lo !== 64'hFFFF_FFFF_FFFF_FFCF) begin failures++; $display("FAIL post_reset_lo got=%h exp=%h", prod_lo, 64'hFFFF_FFFF_FFFF_FFCF); end
      checks++; if (prod_hi !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL post_reset_hi got=%h exp=%h", prod_hi, 64'hFFFF_FFFF_FFFF_FFFF); end
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      a         = '0;
      b         = '0;
      test_reset;
      test_basic_timing;
      test_products;
      test_back_to_back;
      test_reset_mid_run;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
